// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 255;

    // Mul/div sequencing state; MD_DONE holds a completion that landed during a memory wait.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Winning hazard condition for the current cycle, highest priority first.
    typedef enum logic [2:0] {
        COND_NONE    = 3'd0,
        COND_MEMWAIT = 3'd1,
        COND_BRANCH  = 3'd2,
        COND_MDSTALL = 3'd3,
        COND_LOADUSE = 3'd4
    } hz_cond_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear; async active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] r_cnt;

    // Count up on inc, stick at all-ones; clear wins over inc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_cnt <= '0;
        else if (clr)                   r_cnt <= '0;
        else if (inc && (r_cnt != '1))  r_cnt <= r_cnt + ONE;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Lock/flush generation for the five-stage pipeline: memory wait, taken branch,
// multi-cycle mul/div and load-use, resolved under a fixed priority.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_muldiv,
    input  logic             muldiv_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mem_branch_taken,
    output logic             pc_lock,
    output logic             id_lock,
    output logic             ex_lock,
    output logic             mem_lock,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             wb_flush,
    output logic             pc_redirect,
    output logic             muldiv_start,
    output logic             muldiv_abort,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int                WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TO_M1  = WAIT_W'(MEM_TIMEOUT - 1);

    md_state_e         r_state, w_state_nxt;
    hz_cond_e          w_cond;
    logic              w_memwait, w_branch, w_mdstall, w_loaduse;
    logic              r_mem_err;
    logic [WAIT_W-1:0] w_wait_cnt;

    assign w_memwait = mem_req & ~mem_ready;
    assign w_branch  = mem_branch_taken & ~w_memwait;
    // A done pulse while busy lets the EX instruction advance in that same cycle.
    assign w_mdstall = ex_muldiv & ~w_memwait & ~w_branch &
                       ((r_state == MD_IDLE) | ((r_state == MD_BUSY) & ~muldiv_done));
    assign w_loaduse = ex_memread & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Pick the single winning condition for this cycle.
    always_comb begin
        w_cond = COND_NONE;
        if (w_memwait)      w_cond = COND_MEMWAIT;
        else if (w_branch)  w_cond = COND_BRANCH;
        else if (w_mdstall) w_cond = COND_MDSTALL;
        else if (w_loaduse) w_cond = COND_LOADUSE;
    end

    // Mul/div state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Mul/div next state: a branch always cancels; a done under memory wait is parked in MD_DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (ex_muldiv & ~w_memwait & ~w_branch) w_state_nxt = MD_BUSY;
            MD_BUSY: begin
                if (w_branch)                      w_state_nxt = MD_IDLE;
                else if (muldiv_done & ~w_memwait) w_state_nxt = MD_IDLE;
                else if (muldiv_done &  w_memwait) w_state_nxt = MD_DONE;
            end
            MD_DONE: if (~w_memwait) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Pipeline controls from the winning condition; all forced low while in reset.
    always_comb begin
        pc_lock      = 1'b0;
        id_lock      = 1'b0;
        ex_lock      = 1'b0;
        mem_lock     = 1'b0;
        id_flush     = 1'b0;
        ex_flush     = 1'b0;
        mem_flush    = 1'b0;
        wb_flush     = 1'b0;
        pc_redirect  = 1'b0;
        muldiv_start = 1'b0;
        muldiv_abort = 1'b0;
        if (!rst) begin
            case (w_cond)
                COND_MEMWAIT: begin
                    pc_lock  = 1'b1;
                    id_lock  = 1'b1;
                    ex_lock  = 1'b1;
                    mem_lock = 1'b1;
                    wb_flush = 1'b1;
                end
                COND_BRANCH: begin
                    pc_redirect  = 1'b1;
                    id_flush     = 1'b1;
                    ex_flush     = 1'b1;
                    mem_flush    = 1'b1;
                    muldiv_abort = (r_state == MD_BUSY);
                end
                COND_MDSTALL: begin
                    pc_lock      = 1'b1;
                    id_lock      = 1'b1;
                    ex_lock      = 1'b1;
                    mem_flush    = 1'b1;
                    muldiv_start = (r_state == MD_IDLE);
                end
                COND_LOADUSE: begin
                    pc_lock  = 1'b1;
                    id_lock  = 1'b1;
                    ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(pc_lock), .clr(1'b0), .cnt(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc(pc_redirect), .clr(1'b0), .cnt(flush_cnt)
    );

    // Consecutive memory-wait cycles; any cycle without a wait restarts the count.
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk(clk), .rst(rst), .inc(w_memwait), .clr(~w_memwait), .cnt(w_wait_cnt)
    );

    // Sticky timeout flag, set on the edge where the wait count reaches MEM_TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_mem_err <= 1'b0;
        else if (w_memwait && (w_wait_cnt == TO_M1)) r_mem_err <= 1'b1;
    end

    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread, ex_muldiv, muldiv_done;
    logic             mem_req, mem_ready, mem_branch_taken;
    logic             pc_lock, id_lock, ex_lock, mem_lock;
    logic             id_flush, ex_flush, mem_flush, wb_flush;
    logic             pc_redirect, muldiv_start, muldiv_abort, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_muldiv(ex_muldiv), .muldiv_done(muldiv_done),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_branch_taken(mem_branch_taken),
        .pc_lock(pc_lock), .id_lock(id_lock), .ex_lock(ex_lock), .mem_lock(mem_lock),
        .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush), .wb_flush(wb_flush),
        .pc_redirect(pc_redirect), .muldiv_start(muldiv_start), .muldiv_abort(muldiv_abort),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: is a mul/div in flight, is a finished result parked,
    // how long memory has been waiting, and the expected counters.
    bit m_run, m_hold, m_err;
    int m_wait, m_sc, m_fc;
    logic [10:0] m_vec;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {pc_lock, id_lock, ex_lock, mem_lock, id_flush, ex_flush, mem_flush,
                wb_flush, pc_redirect, muldiv_start, muldiv_abort};
    endfunction

    // Expected combinational controls for the current inputs and model state.
    task automatic model_comb();
        bit mw, br, md, lu;
        mw = mem_req && !mem_ready;
        br = mem_branch_taken && !mw;
        md = ex_muldiv && !mw && !br && !m_hold && !(m_run && muldiv_done);
        lu = !mw && !br && !md && ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        m_vec = {mw || md || lu, mw || md || lu, mw || md, mw,
                 br, br || lu, br || md, mw,
                 br, md && !m_run, br && m_run};
    endtask

    // Advance the model across one clock edge.
    task automatic model_seq();
        bit mw, br;
        mw = mem_req && !mem_ready;
        br = mem_branch_taken && !mw;
        if (m_hold) begin
            if (!mw) m_hold = 0;
        end else if (m_run) begin
            if (br) m_run = 0;
            else if (muldiv_done) begin
                m_run  = 0;
                m_hold = mw;
            end
        end else if (ex_muldiv && !mw && !br) begin
            m_run = 1;
        end
        m_wait = mw ? m_wait + 1 : 0;
        if (m_wait >= TO) m_err = 1;
        if (m_vec[10] && m_sc < SAT) m_sc++;
        if (m_vec[2]  && m_fc < SAT) m_fc++;
    endtask

    // One clock: inputs are already driven (after a falling edge); check, then clock.
    task automatic cycle();
        #1;
        model_comb();
        chk("ctrl", 32'(dut_vec()), 32'(m_vec));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_memread = 0; ex_muldiv = 0; muldiv_done = 0;
        mem_req = 0; mem_ready = 0; mem_branch_taken = 0;
    endtask

    // Reset takes effect immediately: all controls and counters must read zero.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'(dut_vec()), 32'd0);
        chk("rst_cnt", {16'(stall_cnt), 16'(flush_cnt)}, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_run = 0; m_hold = 0; m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Load-use on rs2, then the same pattern against x0.
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1;
        chk("lu_lock", {29'd0, pc_lock, id_lock, ex_flush}, 32'b111);
        cycle();
        clear_in(); cycle();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        cycle();
        chk("lu_x0", 32'(stall_cnt), 32'd1);

        // Three memory-wait cycles, released on ready.
        do_reset(); clear_in();
        mem_req = 1;
        repeat (3) cycle();
        mem_ready = 1;
        #1;
        chk("mw_release", 32'(pc_lock), 32'd0);
        cycle();
        chk("mw_cnt", 32'(stall_cnt), 32'd3);

        // Mul/div: four stall cycles, done cycle advances.
        do_reset(); clear_in();
        ex_muldiv = 1;
        #1;
        chk("md_start", 32'(muldiv_start), 32'd1);
        repeat (4) cycle();
        muldiv_done = 1;
        #1;
        chk("md_done_adv", {30'd0, pc_lock, muldiv_start}, 32'd0);
        cycle();
        clear_in(); cycle();
        chk("md_cnt", 32'(stall_cnt), 32'd4);

        // Done coincides with a memory wait: result parked, then no extra stall.
        do_reset(); clear_in();
        ex_muldiv = 1;
        repeat (2) cycle();
        muldiv_done = 1; mem_req = 1;
        cycle();
        muldiv_done = 0;
        cycle();
        mem_ready = 1;
        #1;
        chk("md_parked", {30'd0, pc_lock, muldiv_start}, 32'd0);
        cycle();
        chk("md_park_cnt", 32'(stall_cnt), 32'd4);

        // Branch while mul/div busy aborts it.
        do_reset(); clear_in();
        ex_muldiv = 1;
        repeat (2) cycle();
        mem_branch_taken = 1;
        #1;
        chk("br_abort", {28'd0, muldiv_abort, pc_redirect, ex_flush, mem_flush}, 32'hF);
        cycle();
        clear_in(); cycle();
        chk("br_cnt", 32'(flush_cnt), 32'd1);

        // Branch under memory wait waits for ready.
        do_reset(); clear_in();
        mem_branch_taken = 1; mem_req = 1;
        #1;
        chk("br_mw", 32'(pc_redirect), 32'd0);
        cycle();
        mem_ready = 1;
        cycle();
        chk("br_mw_cnt", {16'(stall_cnt), 16'(flush_cnt)}, {16'd1, 16'd1});

        // Timeout after four waits, sticky, then reset mid-stall.
        do_reset(); clear_in();
        mem_req = 1;
        repeat (3) cycle();
        chk("to_pre", 32'(mem_err), 32'd0);
        cycle();
        chk("to_set", 32'(mem_err), 32'd1);
        repeat (2) cycle();
        chk("to_hold", {31'd0, mem_err}, {31'd0, 1'b1});
        do_reset();

        // Random traffic with small register numbers to provoke load-use hits.
        clear_in();
        for (int i = 0; i < 3000; i++) begin
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            ex_rd            = 5'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom_range(0, 1));
            id_use_rs2       = 1'($urandom_range(0, 1));
            ex_memread       = 1'($urandom_range(0, 1));
            ex_muldiv        = ($urandom_range(0, 9) < 4);
            muldiv_done      = ($urandom_range(0, 3) == 0);
            mem_req          = 1'($urandom_range(0, 1));
            mem_ready        = ($urandom_range(0, 9) < 6);
            mem_branch_taken = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
